// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one word request per cycle
// to a 1-cycle imem, buffers responses and hands them to decode.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DMAX = (CW+1)'(DEPTH);

   typedef enum logic {
      BOOT,
      RUN
   } state_t;

   state_t state, state_next;

   logic [31:0]   pc_q;
   logic [31:0]   req_pc;
   logic [CW-1:0] count;
   logic          inflight;
   logic          kill;
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [31:0]   buf_instr [DEPTH];
   logic [31:0]   buf_pc    [DEPTH];

   logic          run;
   logic          pop;
   logic          push;
   logic          flush;
   logic [CW:0]   occ;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= BOOT;
      else        state <= state_next;
   end

   // Next state, handshake decode and request decision
   always_comb begin
      state_next = state;
      unique case (state)
         BOOT: state_next = RUN;
         RUN:  state_next = RUN;
      endcase
      run   = (state == RUN);
      pop   = if_valid & id_ready;
      flush = run & redirect_valid;
      occ   = {1'b0, count}
            + (CW+1)'(inflight)
            - (CW+1)'(pop);
      imem_req = run & ~redirect_valid & (occ < DMAX);
      push     = inflight & ~kill & ~flush;
   end

   // PC, in-flight tracking and buffer pointers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         req_pc   <= RESET_PC;
         count    <= '0;
         inflight <= 1'b0;
         kill     <= 1'b0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= imem_req;
         kill     <= flush;
         if (imem_req) begin
            pc_q   <= pc_q + PC_STEP;
            req_pc <= pc_q;
         end
         if (flush) begin
            pc_q  <= redirect_pc;
            count <= '0;
            head  <= '0;
            tail  <= '0;
         end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Buffer storage: response word and its fetch address
   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[tail] <= imem_rdata;
         buf_pc[tail]    <= req_pc;
      end
   end

   assign imem_addr = pc_q;
   assign if_valid  = (count != '0);
   assign if_instr  = if_valid ? buf_instr[head] : 32'h0;
   assign if_pc     = if_valid ? buf_pc[head]    : 32'h0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stream, stall, redirect, reset, PC wrap.
// Memory model returns (addr << 4) + 1 one cycle after each request.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready = 1'b0;

   int tests = 0;
   int fails = 0;
   logic [31:0] acc [$];

   fetch_ctrl #(
      .RESET_PC(32'h0),
      .PC_STEP(32'd4),
      .DEPTH(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .if_valid(if_valid),
      .if_instr(if_instr),
      .if_pc(if_pc),
      .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= (imem_addr << 4) + 32'd1;
   end

   // Accepted-instruction log and word/address consistency
   always @(negedge clk) begin
      if (if_valid && id_ready) begin
         acc.push_back(if_pc);
         tests++;
         assert (if_instr === (if_pc << 4) + 32'd1) else begin
            fails++;
            $error("FAIL accept_word got %h want %h",
                   if_instr, (if_pc << 4) + 32'd1);
         end
      end
   end

   // A push into a full buffer with no pop is a design error
   always @(negedge clk) begin
      if (rst_n && dut.push && !dut.pop && dut.count == 2) begin
         fails++;
         $error("FAIL overflow got push at count %0d want none",
                dut.count);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cy(input string tag, input logic req,
                     input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic [31:0] ins);
      @(negedge clk);
      chk({tag, ".req"}, 32'(imem_req), 32'(req));
      chk({tag, ".addr"}, imem_addr, addr);
      chk({tag, ".vld"}, 32'(if_valid), 32'(v));
      if (v) begin
         chk({tag, ".pc"}, if_pc, pc);
         chk({tag, ".ins"}, if_instr, ins);
      end
   endtask

   task automatic do_reset(input logic ir);
      rst_n = 1'b0;
      id_ready = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      adv();
      adv();
      rst_n = 1'b1;
      id_ready = ir;
      acc.delete();
      cy("boot", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("boot.pc0", if_pc, 32'h0);
      chk("boot.ins0", if_instr, 32'h0);
   endtask

   task automatic chk_acc(input string tag, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input logic [31:0] e3);
      chk({tag, ".n"}, 32'(acc.size()), 32'd4);
      if (acc.size() == 4) begin
         chk({tag, ".a0"}, acc[0], e0);
         chk({tag, ".a1"}, acc[1], e1);
         chk({tag, ".a2"}, acc[2], e2);
         chk({tag, ".a3"}, acc[3], e3);
      end
   endtask

   initial begin
      // 1: sequential stream, no bubbles
      do_reset(1'b1);
      adv(); cy("t1c1", 1, 32'h0,  0, 0, 0);
      adv(); cy("t1c2", 1, 32'h4,  0, 0, 0);
      adv(); cy("t1c3", 1, 32'h8,  1, 32'h0, 32'h1);
      adv(); cy("t1c4", 1, 32'hC,  1, 32'h4, 32'h41);
      adv(); cy("t1c5", 1, 32'h10, 1, 32'h8, 32'h81);

      // 2: decode stall for five cycles
      do_reset(1'b0);
      adv(); cy("t2c1", 1, 32'h0, 0, 0, 0);
      adv(); cy("t2c2", 1, 32'h4, 0, 0, 0);
      for (int i = 3; i <= 7; i++) begin
         adv(); cy($sformatf("t2c%0d", i), 0, 32'h8, 1, 32'h0, 32'h1);
      end
      adv(); id_ready = 1'b1;
      cy("t2c8",  1, 32'h8,  1, 32'h0, 32'h1);
      adv(); cy("t2c9",  1, 32'hC,  1, 32'h4, 32'h41);
      adv(); cy("t2c10", 1, 32'h10, 1, 32'h8, 32'h81);
      adv(); cy("t2c11", 1, 32'h14, 1, 32'hC, 32'hC1);
      adv(); chk_acc("t2acc", 32'h0, 32'h4, 32'h8, 32'hC);

      // 3: redirect with head 8 held and C in flight
      do_reset(1'b1);
      adv(); cy("t3c1", 1, 32'h0, 0, 0, 0);
      adv(); cy("t3c2", 1, 32'h4, 0, 0, 0);
      adv(); cy("t3c3", 1, 32'h8, 1, 32'h0, 32'h1);
      adv(); cy("t3c4", 1, 32'hC, 1, 32'h4, 32'h41);
      adv(); id_ready = 1'b0; redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      cy("t3c5", 0, 32'h10, 1, 32'h8, 32'h81);
      adv(); redirect_valid = 1'b0;
      cy("t3c6", 1, 32'h100, 0, 0, 0);
      adv(); cy("t3c7", 1, 32'h104, 0, 0, 0);
      adv(); cy("t3c8", 0, 32'h108, 1, 32'h100, 32'h1001);
      adv(); id_ready = 1'b1;
      cy("t3c9", 1, 32'h108, 1, 32'h100, 32'h1001);
      adv(); cy("t3c10", 1, 32'h10C, 1, 32'h104, 32'h1041);
      adv(); chk_acc("t3acc", 32'h0, 32'h4, 32'h100, 32'h104);

      // 4: redirect coinciding with pop of PC 4
      do_reset(1'b1);
      adv(); cy("t4c1", 1, 32'h0, 0, 0, 0);
      adv(); cy("t4c2", 1, 32'h4, 0, 0, 0);
      adv(); cy("t4c3", 1, 32'h8, 1, 32'h0, 32'h1);
      adv(); redirect_valid = 1'b1; redirect_pc = 32'h200;
      cy("t4c4", 0, 32'hC, 1, 32'h4, 32'h41);
      adv(); redirect_valid = 1'b0;
      cy("t4c5", 1, 32'h200, 0, 0, 0);
      adv(); cy("t4c6", 1, 32'h204, 0, 0, 0);
      adv(); cy("t4c7", 1, 32'h208, 1, 32'h200, 32'h2001);
      adv(); cy("t4c8", 1, 32'h20C, 1, 32'h204, 32'h2041);
      adv(); chk_acc("t4acc", 32'h0, 32'h4, 32'h200, 32'h204);

      // 5: one-cycle reset mid-stream
      do_reset(1'b1);
      adv(); cy("t5c1", 1, 32'h0, 0, 0, 0);
      adv(); cy("t5c2", 1, 32'h4, 0, 0, 0);
      adv(); cy("t5c3", 1, 32'h8, 1, 32'h0, 32'h1);
      adv(); cy("t5c4", 1, 32'hC, 1, 32'h4, 32'h41);
      adv(); rst_n = 1'b0;
      cy("t5c5", 1, 32'h10, 1, 32'h8, 32'h81);
      adv(); rst_n = 1'b1;
      cy("t5c6", 0, 32'h0, 0, 0, 0);
      adv(); cy("t5c7", 1, 32'h0, 0, 0, 0);
      adv(); cy("t5c8", 1, 32'h4, 0, 0, 0);
      adv(); cy("t5c9", 1, 32'h8, 1, 32'h0, 32'h1);

      // 6: redirect to top of address space, PC wraps
      adv(); chk_acc("t5acc", 32'h0, 32'h4, 32'h8, 32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cy("t6c10", 0, 32'hC, 1, 32'h4, 32'h41);
      adv(); redirect_valid = 1'b0;
      cy("t6c11", 1, 32'hFFFF_FFFC, 0, 0, 0);
      adv(); cy("t6c12", 1, 32'h0, 0, 0, 0);
      adv(); cy("t6c13", 1, 32'h4, 1, 32'hFFFF_FFFC, 32'hFFFF_FFC1);
      adv(); cy("t6c14", 1, 32'h8, 1, 32'h0, 32'h1);

      // 7: back-to-back redirects, last wins
      adv(); redirect_valid = 1'b1; redirect_pc = 32'h300;
      cy("t7c15", 0, 32'hC, 1, 32'h4, 32'h41);
      adv(); redirect_pc = 32'h400;
      cy("t7c16", 0, 32'h300, 0, 0, 0);
      adv(); redirect_valid = 1'b0;
      cy("t7c17", 1, 32'h400, 0, 0, 0);
      adv(); cy("t7c18", 1, 32'h404, 0, 0, 0);
      adv(); cy("t7c19", 1, 32'h408, 1, 32'h400, 32'h4001);
      adv();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
